wb_port_arbiter: RTL and testbench

- Shares the register file's two write ports (port 1: reg_write/regd/write_data; port 2: reg_write2/regd2/write_data2) among NUM_SRC writeback requesters, e.g. ALU0, ALU1, load unit and multiplier.
- Arbitration is round-robin, at most two grants per cycle.
- Guarantees that both ports never target the same destination in one cycle, so the register file's collision path is never exercised.
- Outputs are registered and drive the register file write ports directly.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_rr_pick.sv | 43 ++++
 rtl/wb_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback port arbiter.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int SRC_IDX_W  = 3;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    // Successor of a requester index, wrapping back to 0 after n-1.
    function automatic logic [SRC_IDX_W-1:0] rr_next(input logic [SRC_IDX_W-1:0] ptr,
                                                     input int n);
        if (int'(ptr) >= n - 1) begin
            rr_next = '0;
        end else begin
            rr_next = ptr + SRC_IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// One-hot round-robin picker with a starvation override.
// Forced sources win first (lowest index); otherwise the scan starts at ptr and wraps.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         elig,
    input  logic [SRC_IDX_W-1:0] ptr,
    input  logic [N-1:0]         force_mask,
    output logic [N-1:0]         pick
);

    logic [N-1:0] forced;
    logic         found;

    assign forced = elig & force_mask;

    // Select the first eligible source in scan order, forced sources scanned first.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        if (|forced) begin
            for (int i = 0; i < N; i++) begin
                if (!found && forced[i]) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && elig[i] &&
                        ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
                        pick[i] = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter sharing the register file's two write ports among NUM_SRC requesters.
// Round-robin with starvation override; never issues the same rd on both ports in one cycle.
// Requests with rd == 0 are acknowledged without using a port.
// Optional build macro WB_ARB_PERF_EN adds perf_grants / perf_conflicts counters.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          wb_hold,
    output logic                          reg_write,
    output logic [REG_ADDR_W-1:0]         regd,
    output logic [DATA_W-1:0]             write_data,
    output logic                          reg_write2,
    output logic [REG_ADDR_W-1:0]         regd2,
    output logic [DATA_W-1:0]             write_data2
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_grants,
    output logic [31:0]                   perf_conflicts
`endif
);

    localparam int RD_W  = $clog2(NUM_REGS);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [RD_W-1:0]      rd_of      [NUM_SRC];
    logic [DATA_W-1:0]    data_of    [NUM_SRC];
    logic [CNT_W-1:0]     starve_cnt [NUM_SRC];
    logic [NUM_SRC-1:0]   elig;
    logic [NUM_SRC-1:0]   elig2;
    logic [NUM_SRC-1:0]   zero_req;
    logic [NUM_SRC-1:0]   force_mask;
    logic [NUM_SRC-1:0]   pick1;
    logic [NUM_SRC-1:0]   pick2;
    logic [RD_W-1:0]      rd1;
    logic [RD_W-1:0]      rd2;
    logic [DATA_W-1:0]    data1;
    logic [DATA_W-1:0]    data2;
    logic [SRC_IDX_W-1:0] rr_ptr;
    logic [SRC_IDX_W-1:0] last_idx;
    logic                 grant1;
    logic                 grant2;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign rd_of[g]      = src_rd[g*REG_ADDR_W +: REG_ADDR_W];
        assign data_of[g]    = src_data[g*DATA_W +: DATA_W];
        assign elig[g]       = src_valid[g] && (rd_of[g] != '0);
        assign zero_req[g]   = src_valid[g] && (rd_of[g] == '0);
        assign force_mask[g] = (starve_cnt[g] == CNT_W'(STARVE_MAX));
        assign elig2[g]      = elig[g] && !pick1[g] && (rd_of[g] != rd1);
    end

    wb_rr_pick #(.N(NUM_SRC)) u_pick1 (
        .elig       (elig),
        .ptr        (rr_ptr),
        .force_mask (force_mask),
        .pick       (pick1)
    );

    wb_rr_pick #(.N(NUM_SRC)) u_pick2 (
        .elig       (elig2),
        .ptr        (rr_ptr),
        .force_mask (force_mask),
        .pick       (pick2)
    );

    assign grant1 = !wb_hold && (|pick1);
    assign grant2 = !wb_hold && (|pick2);

    // Route the port-1 winner's rd and data (pick1 is one-hot or empty).
    always_comb begin
        rd1   = '0;
        data1 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick1[i]) begin
                rd1   = rd_of[i];
                data1 = data_of[i];
            end
        end
    end

    // Route the port-2 winner's rd and data.
    always_comb begin
        rd2   = '0;
        data2 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick2[i]) begin
                rd2   = rd_of[i];
                data2 = data_of[i];
            end
        end
    end

    // Index of the last source granted a port in scan order: port 2 if used, else port 1.
    always_comb begin
        last_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((|pick2) ? pick2[i] : pick1[i]) begin
                last_idx = SRC_IDX_W'(i);
            end
        end
    end

    // Handshake: rd==0 requests are acknowledged free of charge; nothing is granted under hold or reset.
    always_comb begin
        if (rst || wb_hold) begin
            src_ready = '0;
        end else begin
            src_ready = pick1 | pick2 | zero_req;
        end
    end

    // Registered write ports; enables pulse for one cycle, rd/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write   <= 1'b0;
            regd        <= '0;
            write_data  <= '0;
            reg_write2  <= 1'b0;
            regd2       <= '0;
            write_data2 <= '0;
        end else begin
            reg_write  <= grant1;
            reg_write2 <= grant2;
            if (grant1) begin
                regd       <= REG_ADDR_W'(rd1);
                write_data <= data1;
            end
            if (grant2) begin
                regd2       <= REG_ADDR_W'(rd2);
                write_data2 <= data2;
            end
        end
    end

    // Advance the round-robin pointer past the last port-granted source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant1 || grant2) begin
            rr_ptr <= rr_next(last_idx, NUM_SRC);
        end
    end

    // Count waiting cycles per source, saturating so the source becomes forced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                starve_cnt[i] <= '0;
            end
        end else if (!wb_hold) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_valid[i] || src_ready[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != CNT_W'(STARVE_MAX)) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [1:0] writes_now;
    logic       denied_now;

    assign writes_now = {1'b0, grant1} + {1'b0, grant2};
    assign denied_now = |(elig & ~pick1 & ~pick2);

    // Performance counters: port writes issued and cycles with a denied eligible source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grants    <= '0;
            perf_conflicts <= '0;
        end else if (!wb_hold) begin
            perf_grants <= perf_grants + 32'(writes_now);
            if (denied_now) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all compared against a scan-order reference model of the arbitration rules.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int SMAX = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N*5-1:0]  src_rd;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic            wb_hold;
    logic            reg_write;
    logic [4:0]      regd;
    logic [DW-1:0]   write_data;
    logic            reg_write2;
    logic [4:0]      regd2;
    logic [DW-1:0]   write_data2;
`ifdef WB_ARB_PERF_EN
    logic [31:0]     perf_grants;
    logic [31:0]     perf_conflicts;
`endif

    wb_port_arbiter #(.NUM_SRC(N), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_rd      (src_rd),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .wb_hold     (wb_hold),
        .reg_write   (reg_write),
        .regd        (regd),
        .write_data  (write_data),
        .reg_write2  (reg_write2),
        .regd2       (regd2),
        .write_data2 (write_data2)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_grants    (perf_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    wb_req_t      req [N];
    logic         hold_in;
    int           m_rr;
    int           m_starve [N];
    logic         m_rw1, m_rw2;
    logic [4:0]   m_rd1, m_rd2;
    logic [31:0]  m_d1, m_d2;
    logic [N-1:0] obs_ready;
    int           got;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            src_valid[i]         = req[i].valid;
            src_rd[i*5 +: 5]     = req[i].rd;
            src_data[i*DW +: DW] = req[i].data;
        end
        wb_hold = hold_in;
    endtask

    task automatic setReq(input int i, input logic [4:0] rd, input logic [31:0] data);
        req[i].valid = 1'b1;
        req[i].rd    = rd;
        req[i].data  = data;
    endtask

    task automatic modelReset();
        m_rr  = 0;
        m_rw1 = 1'b0;
        m_rw2 = 1'b0;
        m_rd1 = '0;
        m_rd2 = '0;
        m_d1  = '0;
        m_d2  = '0;
        for (int i = 0; i < N; i++) begin
            m_starve[i]  = 0;
            req[i].valid = 1'b0;
            req[i].rd    = '0;
            req[i].data  = '0;
        end
    endtask

    // Scan order: starving sources by index, then the ring starting at the pointer.
    function automatic void modelPick(output int p1, output int p2);
        int order[$];
        int s;
        p1 = -1;
        p2 = -1;
        for (int i = 0; i < N; i++)
            if (req[i].valid && m_starve[i] == SMAX) order.push_back(i);
        for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
        foreach (order[j]) begin
            s = order[j];
            if (!req[s].valid || req[s].rd == '0) continue;
            if (p1 < 0) p1 = s;
            else if (p2 < 0 && s != p1 && req[s].rd != req[p1].rd) p2 = s;
        end
    endfunction

    // One clock cycle: drive, check grants, clock, update model, check ports.
    task automatic step();
        int p1, p2;
        logic [N-1:0] exp_ready;
        applyStimulus();
        #1;
        modelPick(p1, p2);
        exp_ready = '0;
        if (!hold_in)
            for (int i = 0; i < N; i++)
                if (req[i].valid && (i == p1 || i == p2 || req[i].rd == '0)) exp_ready[i] = 1'b1;
        obs_ready = src_ready;
        checkOutput("src_ready", 64'(src_ready), 64'(exp_ready));
        @(posedge clk);
        if (hold_in) begin
            m_rw1 = 1'b0;
            m_rw2 = 1'b0;
        end else begin
            m_rw1 = (p1 >= 0);
            m_rw2 = (p2 >= 0);
            if (p1 >= 0) begin m_rd1 = req[p1].rd; m_d1 = req[p1].data; end
            if (p2 >= 0) begin m_rd2 = req[p2].rd; m_d2 = req[p2].data; end
            if (p2 >= 0) m_rr = (p2 + 1) % N;
            else if (p1 >= 0) m_rr = (p1 + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (!req[i].valid || exp_ready[i]) m_starve[i] = 0;
                else if (m_starve[i] < SMAX) m_starve[i]++;
            end
            for (int i = 0; i < N; i++) if (exp_ready[i]) req[i].valid = 1'b0;
        end
        #1;
        checkOutput("reg_write",   64'(reg_write),   64'(m_rw1));
        checkOutput("regd",        64'(regd),        64'(m_rd1));
        checkOutput("write_data",  64'(write_data),  64'(m_d1));
        checkOutput("reg_write2",  64'(reg_write2),  64'(m_rw2));
        checkOutput("regd2",       64'(regd2),       64'(m_rd2));
        checkOutput("write_data2", 64'(write_data2), 64'(m_d2));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 12; c++) begin
            if (!(req[0].valid || req[1].valid || req[2].valid || req[3].valid)) break;
            step();
        end
    endtask

    // Grant a lone source so the pointer lands on target (assumes nothing pending).
    task automatic setPtr(input int target);
        setReq((target + N - 1) % N, 5'd9, $urandom);
        step();
    endtask

    initial begin
        rst     = 1'b0;
        hold_in = 1'b0;
        modelReset();
        setReq(0, 5'd1, 32'h1);
        applyStimulus();
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_ready",   64'(src_ready),   64'(0));
        checkOutput("rst_rw",      64'(reg_write),   64'(0));
        checkOutput("rst_rw2",     64'(reg_write2),  64'(0));
        checkOutput("rst_regd",    64'(regd),        64'(0));
        checkOutput("rst_regd2",   64'(regd2),       64'(0));
        checkOutput("rst_wdata",   64'(write_data),  64'(0));
        checkOutput("rst_wdata2",  64'(write_data2), 64'(0));
        modelReset();
        applyStimulus();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Dual grant from pointer 0
        setReq(0, 5'd3, 32'hA);
        setReq(2, 5'd7, 32'hB);
        step();
        checkOutput("dual_ready",  64'(obs_ready),   64'(4'b0101));
        checkOutput("dual_rw",     64'(reg_write),   64'(1));
        checkOutput("dual_regd",   64'(regd),        64'(3));
        checkOutput("dual_wdata",  64'(write_data),  64'(32'hA));
        checkOutput("dual_rw2",    64'(reg_write2),  64'(1));
        checkOutput("dual_regd2",  64'(regd2),       64'(7));
        checkOutput("dual_wdata2", 64'(write_data2), 64'(32'hB));

        // Same-rd conflict from pointer 1
        setPtr(1);
        setReq(1, 5'd5, 32'h11);
        setReq(3, 5'd5, 32'h33);
        step();
        checkOutput("conf_ready1", 64'(obs_ready),   64'(4'b0010));
        checkOutput("conf_regd1",  64'(regd),        64'(5));
        checkOutput("conf_wdata1", 64'(write_data),  64'(32'h11));
        checkOutput("conf_rw2",    64'(reg_write2),  64'(0));
        step();
        checkOutput("conf_ready2", 64'(obs_ready),   64'(4'b1000));
        checkOutput("conf_regd2",  64'(regd),        64'(5));
        checkOutput("conf_wdata2", 64'(write_data),  64'(32'h33));

        // Round-robin fairness with four distinct destinations
        setPtr(0);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) if (!req[i].valid) setReq(i, 5'(i + 1), $urandom);
            step();
            checkOutput("rr_ready", 64'(obs_ready), (c == 1) ? 64'(4'b1100) : 64'(4'b0011));
        end
        drain();

        // rd == 0 is acknowledged without a port write
        setReq(0, 5'd0, 32'hDEAD);
        step();
        checkOutput("rd0_ready", 64'(obs_ready),  64'(4'b0001));
        checkOutput("rd0_rw",    64'(reg_write),  64'(0));
        checkOutput("rd0_rw2",   64'(reg_write2), 64'(0));

        // Pinned pattern that starves src3 until the override kicks in
        setPtr(1);
        setReq(3, 5'd5, 32'h3333);
        got = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            if (!req[0].valid) setReq(0, 5'd6, $urandom);
            if (!req[1].valid) setReq(1, 5'd5, $urandom);
            step();
            if (obs_ready[3]) got = c;
        end
        checkOutput("starve_wait",  64'(got),        64'(SMAX + 1));
        checkOutput("starve_regd",  64'(regd),       64'(5));
        checkOutput("starve_wdata", 64'(write_data), 64'(32'h3333));
        drain();

        // Pipeline freeze for three cycles, then resume from the held pointer
        setPtr(2);
        for (int i = 0; i < N; i++) setReq(i, 5'(i + 11), $urandom);
        hold_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("hold_ready", 64'(obs_ready),  64'(0));
            checkOutput("hold_rw",    64'(reg_write),  64'(0));
            checkOutput("hold_rw2",   64'(reg_write2), 64'(0));
        end
        hold_in = 1'b0;
        step();
        checkOutput("resume_ready", 64'(obs_ready), 64'(4'b1100));
        checkOutput("resume_regd",  64'(regd),      64'(13));
        checkOutput("resume_regd2", 64'(regd2),     64'(14));
        drain();

        // Asynchronous reset in the middle of a write cycle
        setReq(0, 5'd3, 32'h5);
        setReq(1, 5'd4, 32'h6);
        step();
        checkOutput("pre_rst_rw", 64'(reg_write), 64'(1));
        setReq(2, 5'd6, 32'h7);
        applyStimulus();
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_rw",    64'(reg_write),  64'(0));
        checkOutput("arst_rw2",   64'(reg_write2), 64'(0));
        checkOutput("arst_ready", 64'(src_ready),  64'(0));
        modelReset();
        applyStimulus();
        @(negedge clk);
        rst = 1'b0;
        setReq(1, 5'd8, 32'h81);
        setReq(3, 5'd9, 32'h93);
        step();
        checkOutput("post_rst_regd",  64'(regd),  64'(8));
        checkOutput("post_rst_regd2", 64'(regd2), 64'(9));
        drain();

        // Random traffic with a narrow rd range to provoke conflicts
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req[i].valid && $urandom_range(0, 99) < 60)
                    setReq(i, 5'($urandom_range(0, 4)), $urandom);
            hold_in = ($urandom_range(0, 9) == 0);
            step();
        end
        hold_in = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
